// File: rtl/console_pkg.sv
// Shared state encoding and character codes for the text console writer.
package console_pkg;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } console_state_t;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_BLANK = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/vm_clear_seq.sv
// Cell pointer generator for blanking either the whole screen or a single row.
module vm_clear_seq #(
  parameter int unsigned COLS  = 32,
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COL_W = 5,
  parameter int unsigned ROW_W = 5
) (
  input  logic             clk_50mhz,
  input  logic             rst_n,
  input  logic             start,
  input  logic             row_only,
  input  logic [ROW_W-1:0] row,
  output logic [ROW_W-1:0] ptr_row,
  output logic [COL_W-1:0] ptr_col,
  output logic             busy,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic row_only_q;

  assign last = busy && (ptr_col == COL_LAST) && (row_only_q || (ptr_row == ROW_LAST));

  // Reset leaves a full-screen clear armed at (0,0).
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      busy       <= 1'b1;
      row_only_q <= 1'b0;
      ptr_row    <= '0;
      ptr_col    <= '0;
    end else if (start) begin
      busy       <= 1'b1;
      row_only_q <= row_only;
      ptr_row    <= row_only ? row : '0;
      ptr_col    <= '0;
    end else if (busy) begin
      if (last) begin
        busy <= 1'b0;
      end else if (ptr_col == COL_LAST) begin
        ptr_col <= '0;
        ptr_row <= (ptr_row == ROW_LAST) ? '0 : ptr_row + ROW_W'(1);
      end else begin
        ptr_col <= ptr_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte stream to character-cell video RAM writer with cursor, control codes and screen/row clearing.
module text_console_writer
  import console_pkg::*;
#(
  parameter int unsigned COLS   = 32,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned COL_W  = 5,
  parameter int unsigned ROW_W  = 5,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_50mhz,
  input  logic              rst_n,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              vm_we,
  output logic [ADDR_W-1:0] vm_addr,
  output logic [7:0]        vm_din,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  console_state_t    state, state_nx;
  logic [ROW_W-1:0]  row_nx, row_inc;
  logic [COL_W-1:0]  col_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [7:0]        din_nx;
  logic              accept, newline;
  logic              seq_start, seq_row_only, seq_busy, seq_last;
  logic [ROW_W-1:0]  ptr_row;
  logic [COL_W-1:0]  ptr_col;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[COL_W +: ROW_W] = r;
    a[COL_W-1:0]      = c;
    return a;
  endfunction

  assign accept  = char_valid && char_ready;
  assign row_inc = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_W'(1);

  vm_clear_seq #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_clear (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .start     (seq_start),
    .row_only  (seq_row_only),
    .row       (row_inc),
    .ptr_row   (ptr_row),
    .ptr_col   (ptr_col),
    .busy      (seq_busy),
    .last      (seq_last)
  );

  always_comb begin
    state_nx     = state;
    row_nx       = cursor_row;
    col_nx       = cursor_col;
    we_nx        = 1'b0;
    addr_nx      = vm_addr;
    din_nx       = vm_din;
    seq_start    = 1'b0;
    seq_row_only = 1'b0;
    newline      = 1'b0;
    unique case (state)
      CLR_ALL, CLR_ROW: begin
        we_nx   = seq_busy;
        addr_nx = cell_addr(ptr_row, ptr_col);
        din_nx  = CH_BLANK;
        if (seq_last || !seq_busy) begin
          state_nx = IDLE;
          if (state == CLR_ALL) begin
            row_nx = '0;
            col_nx = '0;
          end
        end
      end
      IDLE: begin
        if (accept) begin
          if (is_printable(char_data)) begin
            we_nx   = 1'b1;
            addr_nx = cell_addr(cursor_row, cursor_col);
            din_nx  = char_data;
            if (cursor_col == COL_LAST) newline = 1'b1;
            else                        col_nx  = cursor_col + COL_W'(1);
          end else if (char_data == CH_CR) begin
            col_nx = '0;
          end else if (char_data == CH_LF) begin
            newline = 1'b1;
          end else if (char_data == CH_BS) begin
            if (cursor_col != '0) begin
              col_nx  = cursor_col - COL_W'(1);
              we_nx   = 1'b1;
              addr_nx = cell_addr(cursor_row, cursor_col - COL_W'(1));
              din_nx  = CH_BLANK;
            end
          end else if (char_data == CH_FF) begin
            row_nx    = '0;
            col_nx    = '0;
            state_nx  = CLR_ALL;
            seq_start = 1'b1;
          end
          // A printable in the last column writes its own cell first; the row clear follows.
          if (newline) begin
            col_nx       = '0;
            row_nx       = row_inc;
            state_nx     = CLR_ROW;
            seq_start    = 1'b1;
            seq_row_only = 1'b1;
          end
        end
      end
      default: state_nx = CLR_ALL;
    endcase
  end

  // char_ready lags entry into IDLE by one cycle so it rises after the final clear write.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state      <= CLR_ALL;
      cursor_row <= '0;
      cursor_col <= '0;
      char_ready <= 1'b0;
      vm_we      <= 1'b0;
      vm_addr    <= '0;
      vm_din     <= '0;
    end else begin
      state      <= state_nx;
      cursor_row <= row_nx;
      cursor_col <= col_nx;
      char_ready <= (state == IDLE) && (state_nx == IDLE);
      vm_we      <= we_nx;
      vm_addr    <= addr_nx;
      vm_din     <= din_nx;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer.
module tb_text_console_writer;

  logic        clk_50mhz;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        vm_we;
  logic [11:0] vm_addr;
  logic [7:0]  vm_din;
  logic [4:0]  cursor_row;
  logic [4:0]  cursor_col;

  int vectors;
  int miscompares;

  text_console_writer #(
    .COLS   (32),
    .ROWS   (30),
    .COL_W  (5),
    .ROW_W  (5),
    .ADDR_W (12)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .vm_we      (vm_we),
    .vm_addr    (vm_addr),
    .vm_din     (vm_din),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (!char_ready && n < 2000) begin
      step();
      n++;
    end
    if (!char_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_wait: char_ready=%0b required 1", char_ready);
    end
    char_valid = 1'b1;
    char_data  = b;
    step();
    char_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({vm_we, vm_addr, vm_din, char_ready, cursor_row, cursor_col} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_vals: we=%0b addr=%0d din=%h rdy=%0b cur=(%0d,%0d) required all zero",
               vm_we, vm_addr, vm_din, char_ready, cursor_row, cursor_col);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 960; i++) begin
      step();
      vectors++;
      if (vm_we !== 1'b1 || vm_addr !== 12'(i) || vm_din !== 8'h20 || char_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_clear[%0d]: we=%0b addr=%0d din=%h rdy=%0b required 1/%0d/20/0",
                 i, vm_we, vm_addr, vm_din, char_ready, i);
      end
    end
    step();
    vectors++;
    if (vm_we !== 1'b0 || char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_done: we=%0b rdy=%0b cur=(%0d,%0d) required 0/1/(0,0)",
               vm_we, char_ready, cursor_row, cursor_col);
    end
  endtask

  task automatic test_single_char();
    send(8'h41);
    vectors++;
    if (vm_we !== 1'b1 || vm_addr !== 12'd0 || vm_din !== 8'h41 || cursor_row !== 5'd0 || cursor_col !== 5'd1) begin
      miscompares++;
      $display("FAIL single_char: we=%0b addr=%0d din=%h cur=(%0d,%0d) required 1/0/41/(0,1)",
               vm_we, vm_addr, vm_din, cursor_row, cursor_col);
    end
    step();
    vectors++;
    if (vm_we !== 1'b0 || vm_addr !== 12'd0 || vm_din !== 8'h41 || char_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_hold: we=%0b addr=%0d din=%h rdy=%0b required 0/0/41/1",
               vm_we, vm_addr, vm_din, char_ready);
    end
  endtask

  task automatic test_row_fill();
    send(8'h0D);
    vectors++;
    if (vm_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      miscompares++;
      $display("FAIL cr: we=%0b cur=(%0d,%0d) required 0/(0,0)", vm_we, cursor_row, cursor_col);
    end
    for (int i = 0; i < 32; i++) begin
      char_valid = 1'b1;
      char_data  = 8'h30 + 8'(i);
      step();
      vectors++;
      if (vm_we !== 1'b1 || vm_addr !== 12'(i) || vm_din !== 8'h30 + 8'(i)) begin
        miscompares++;
        $display("FAIL fill[%0d]: we=%0b addr=%0d din=%h required 1/%0d/%h",
                 i, vm_we, vm_addr, vm_din, i, 8'h30 + 8'(i));
      end
    end
    char_valid = 1'b0;
    vectors++;
    if (char_ready !== 1'b0 || cursor_row !== 5'd1 || cursor_col !== 5'd0) begin
      miscompares++;
      $display("FAIL fill_newline: rdy=%0b cur=(%0d,%0d) required 0/(1,0)", char_ready, cursor_row, cursor_col);
    end
    for (int j = 0; j < 32; j++) begin
      step();
      vectors++;
      if (vm_we !== 1'b1 || vm_addr !== 12'(32 + j) || vm_din !== 8'h20 || char_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_clr[%0d]: we=%0b addr=%0d din=%h rdy=%0b required 1/%0d/20/0",
                 j, vm_we, vm_addr, vm_din, char_ready, 32 + j);
      end
    end
    step();
    vectors++;
    if (vm_we !== 1'b0 || char_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_done: we=%0b rdy=%0b required 0/1", vm_we, char_ready);
    end
  endtask

  task automatic test_wrap();
    repeat (28) send(8'h0A);
    repeat (5) send(8'h78);
    vectors++;
    if (cursor_row !== 5'd29 || cursor_col !== 5'd5) begin
      miscompares++;
      $display("FAIL wrap_setup: cur=(%0d,%0d) required (29,5)", cursor_row, cursor_col);
    end
    send(8'h0A);
    vectors++;
    if (vm_we !== 1'b0 || char_ready !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      miscompares++;
      $display("FAIL wrap_lf: we=%0b rdy=%0b cur=(%0d,%0d) required 0/0/(0,0)",
               vm_we, char_ready, cursor_row, cursor_col);
    end
    for (int j = 0; j < 32; j++) begin
      step();
      vectors++;
      if (vm_we !== 1'b1 || vm_addr !== 12'(j) || vm_din !== 8'h20) begin
        miscompares++;
        $display("FAIL wrap_clr[%0d]: we=%0b addr=%0d din=%h required 1/%0d/20", j, vm_we, vm_addr, vm_din, j);
      end
    end
    send(8'h08);
    vectors++;
    if (vm_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      miscompares++;
      $display("FAIL bs_col0: we=%0b cur=(%0d,%0d) required 0/(0,0)", vm_we, cursor_row, cursor_col);
    end
    send(8'h41);
    send(8'h42);
    vectors++;
    if (vm_addr !== 12'd1 || vm_din !== 8'h42 || cursor_col !== 5'd2) begin
      miscompares++;
      $display("FAIL ab: addr=%0d din=%h col=%0d required 1/42/2", vm_addr, vm_din, cursor_col);
    end
    send(8'h08);
    vectors++;
    if (vm_we !== 1'b1 || vm_addr !== 12'd1 || vm_din !== 8'h20 || cursor_row !== 5'd0 || cursor_col !== 5'd1) begin
      miscompares++;
      $display("FAIL bs: we=%0b addr=%0d din=%h cur=(%0d,%0d) required 1/1/20/(0,1)",
               vm_we, vm_addr, vm_din, cursor_row, cursor_col);
    end
  endtask

  task automatic test_form_feed();
    repeat (7) send(8'h0A);
    repeat (9) send(8'h2E);
    vectors++;
    if (cursor_row !== 5'd7 || cursor_col !== 5'd9) begin
      miscompares++;
      $display("FAIL ff_setup: cur=(%0d,%0d) required (7,9)", cursor_row, cursor_col);
    end
    send(8'h0C);
    char_valid = 1'b1;
    char_data  = 8'h5A;
    vectors++;
    if (vm_we !== 1'b0 || char_ready !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin
      miscompares++;
      $display("FAIL ff: we=%0b rdy=%0b cur=(%0d,%0d) required 0/0/(0,0)",
               vm_we, char_ready, cursor_row, cursor_col);
    end
    for (int i = 0; i < 960; i++) begin
      step();
      vectors++;
      if (vm_we !== 1'b1 || vm_addr !== 12'(i) || vm_din !== 8'h20 || char_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ff_clr[%0d]: we=%0b addr=%0d din=%h rdy=%0b required 1/%0d/20/0",
                 i, vm_we, vm_addr, vm_din, char_ready, i);
      end
    end
    step();
    vectors++;
    if (vm_we !== 1'b0 || char_ready !== 1'b1 || cursor_col !== 5'd0) begin
      miscompares++;
      $display("FAIL ff_done: we=%0b rdy=%0b col=%0d required 0/1/0", vm_we, char_ready, cursor_col);
    end
    step();
    char_valid = 1'b0;
    vectors++;
    if (vm_we !== 1'b1 || vm_addr !== 12'd0 || vm_din !== 8'h5A || cursor_col !== 5'd1) begin
      miscompares++;
      $display("FAIL ff_held_z: we=%0b addr=%0d din=%h col=%0d required 1/0/5a/1", vm_we, vm_addr, vm_din, cursor_col);
    end
    step();
    vectors++;
    if (vm_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd1) begin
      miscompares++;
      $display("FAIL ff_z_once: we=%0b cur=(%0d,%0d) required 0/(0,1)", vm_we, cursor_row, cursor_col);
    end
  endtask

  task automatic test_other_bytes();
    send(8'h7F);
    vectors++;
    if (vm_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd1 || char_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ctrl_ignored: we=%0b rdy=%0b cur=(%0d,%0d) required 0/1/(0,1)",
               vm_we, char_ready, cursor_row, cursor_col);
    end
    send(8'h7E);
    vectors++;
    if (vm_we !== 1'b1 || vm_addr !== 12'd1 || vm_din !== 8'h7E || cursor_col !== 5'd2) begin
      miscompares++;
      $display("FAIL tilde: we=%0b addr=%0d din=%h col=%0d required 1/1/7e/2", vm_we, vm_addr, vm_din, cursor_col);
    end
  endtask

  task automatic test_reset_mid_clear();
    send(8'h0A);
    for (int j = 0; j < 10; j++) begin
      step();
      vectors++;
      if (vm_we !== 1'b1 || vm_addr !== 12'(32 + j)) begin
        miscompares++;
        $display("FAIL mid_clr[%0d]: we=%0b addr=%0d required 1/%0d", j, vm_we, vm_addr, 32 + j);
      end
    end
    rst_n = 1'b0;
    step();
    vectors++;
    if (vm_we !== 1'b0 || vm_addr !== 12'd0 || char_ready !== 1'b0 || cursor_row !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_reset: we=%0b addr=%0d rdy=%0b row=%0d required 0/0/0/0",
               vm_we, vm_addr, char_ready, cursor_row);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 960; i++) begin
      step();
      vectors++;
      if (vm_we !== 1'b1 || vm_addr !== 12'(i) || vm_din !== 8'h20) begin
        miscompares++;
        $display("FAIL restart_clr[%0d]: we=%0b addr=%0d din=%h required 1/%0d/20", i, vm_we, vm_addr, vm_din, i);
      end
    end
    step();
    vectors++;
    if (vm_we !== 1'b0 || char_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_done: we=%0b rdy=%0b required 0/1", vm_we, char_ready);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    char_valid  = 1'b0;
    char_data   = 8'h00;
    test_reset();
    test_single_char();
    test_row_fill();
    test_wrap();
    test_form_feed();
    test_other_bytes();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
